tinker_fetch_buffer: RTL

TINKER_FETCH_BUFFER -- requirements
Module: tinker_fetch_buffer

---
 rtl/tinker_pkg.sv | 15 +
 rtl/tinker_fetch_ram.sv | 26 ++
 rtl/tinker_fetch_buffer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/tinker_pkg.sv
// Shared constants and the fetch queue entry layout.
// Used by tinker_fetch_buffer (optional TINKER_FETCH_BYPASS_EN feature).
package tinker_pkg;

    localparam logic [63:0] TINKER_RESET_PC  = 64'h2000;
    localparam int          TINKER_INST_STEP = 4;
    localparam int          TINKER_PC_W      = 64;
    localparam int          TINKER_INST_W    = 32;

    typedef struct packed {
        logic [TINKER_PC_W-1:0]   pc;
        logic [TINKER_INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/tinker_fetch_ram.sv
// Simple dual-port storage: one synchronous write, one async read.
// The array is not reset; validity is tracked by the owner's pointers.
module tinker_fetch_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tinker_fetch_buffer.sv
// Instruction fetch queue with redirect flush and in-flight response discard.
// Define TINKER_FETCH_BYPASS_EN to forward a response straight to out_* when empty.
module tinker_fetch_buffer
    import tinker_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 64,
    parameter int          INST_W   = 32,
    parameter logic [63:0] RESET_PC = TINKER_RESET_PC,
    parameter int          STEP     = TINKER_INST_STEP
) (
    input  logic              clk,
    input  logic              reset,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_ready,
    input  logic              resp_valid,
    input  logic [INST_W-1:0] resp_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + INST_W;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_outst;
    logic [CNT_W-1:0]  r_discard;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W-1:0]  r_pc_wptr;
    logic [PTR_W-1:0]  r_pc_rptr;

    logic [CNT_W:0]    w_sum;
    logic              w_req_valid;
    logic              w_fire;
    logic              w_keep;
    logic              w_byp;
    logic              w_out_valid;
    logic              w_pop;
    logic              w_wr;
    logic              w_rd;
    logic [ADDR_W-1:0] w_resp_pc;
    logic [ENT_W-1:0]  w_head;
    logic [ADDR_W-1:0] w_head_pc;
    logic [INST_W-1:0] w_head_inst;

    // Credit check: buffered plus in-flight must leave room for one more.
    assign w_sum       = {1'b0, r_count} + {1'b0, r_outst};
    assign w_req_valid = ~reset & ~redirect_valid
                       & (w_sum < (CNT_W+1)'(DEPTH));
    assign w_fire      = w_req_valid & req_ready;

    // Responses for a flushed stream are counted off by r_discard.
    assign w_keep = resp_valid & (r_discard == '0) & ~redirect_valid;

`ifdef TINKER_FETCH_BYPASS_EN
    assign w_byp = w_keep & (r_count == '0);
`else
    assign w_byp = 1'b0;
`endif

    assign w_out_valid = ~reset & ((r_count != '0) | w_byp);
    assign w_pop       = w_out_valid & out_ready & ~redirect_valid;
    assign w_wr        = w_keep & ~(w_byp & w_pop);
    assign w_rd        = w_pop & ~w_byp;

    assign w_head_pc   = w_head[ENT_W-1 -: ADDR_W];
    assign w_head_inst = w_head[INST_W-1:0];

    assign req_valid = w_req_valid;
    assign req_addr  = r_fetch_pc;
    assign out_valid = w_out_valid;
    assign out_pc    = ~w_out_valid ? '0
                     : (w_byp ? w_resp_pc : w_head_pc);
    assign out_inst  = ~w_out_valid ? '0
                     : (w_byp ? resp_inst : w_head_inst);

    // Fetch PC: redirect target, else sequential advance on each fire
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= ADDR_W'(RESET_PC);
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
        end else if (w_fire) begin
            r_fetch_pc <= r_fetch_pc + ADDR_W'(STEP);
        end
    end

    // In-flight request count and stale-response discard counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outst   <= '0;
            r_discard <= '0;
        end else begin
            r_outst <= r_outst + CNT_W'(w_fire) - CNT_W'(resp_valid);
            if (redirect_valid) begin
                r_discard <= r_outst - CNT_W'(resp_valid);
            end else if (resp_valid && (r_discard != '0)) begin
                r_discard <= r_discard - CNT_W'(1);
            end
        end
    end

    // Instruction queue occupancy and pointers; redirect flushes it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else if (redirect_valid) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
            r_wptr  <= r_wptr + PTR_W'(w_wr);
            r_rptr  <= r_rptr + PTR_W'(w_rd);
        end
    end

    // Per-request PC FIFO pointers; survives redirect so stale responses still retire
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_wptr <= '0;
            r_pc_rptr <= '0;
        end else begin
            r_pc_wptr <= r_pc_wptr + PTR_W'(w_fire);
            r_pc_rptr <= r_pc_rptr + PTR_W'(resp_valid);
        end
    end

    tinker_fetch_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W)
    ) u_pc_fifo (
        .clk     (clk),
        .i_we    (w_fire),
        .i_waddr (r_pc_wptr),
        .i_wdata (r_fetch_pc),
        .i_raddr (r_pc_rptr),
        .o_rdata (w_resp_pc)
    );

    tinker_fetch_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_inst_q (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wptr),
        .i_wdata ({w_resp_pc, resp_inst}),
        .i_raddr (r_rptr),
        .o_rdata (w_head)
    );

endmodule
